loop_unit: RTL and testbench
============================

Name: loop_unit

Overview:
- Bracket-control stage directly downstream of the accumulator unit; consumes its acc_zero flag.
- Resolves loop open/close instructions: pushes loop-start addresses, issues back-jumps and runs forward skip scans over loop bodies.
- Feeds the fetch/PC logic: jump/jump_target redirect the PC; skip tells the control unit to suppress side effects while the PC keeps advancing.

Parameters:
- PC_W, 16, program-counter width.
- DEPTH, 16, loop-stack entries; power of two, >= 2.
- SKIP_W, 8, width of the nesting counter used during a skip scan.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- instr_valid  in  1  current instruction accepted this cycle.
- is_open  in  1  accepted instruction is loop-open.
- is_close  in  1  accepted instruction is loop-close.
- pc  in  PC_W  address of the accepted instruction.
- acc_zero  in  1  accumulator-zero flag from the accumulator unit.
- skip  out  1  high while in SKIP; control suppresses every non-bracket side effect.
- jump  out  1  one-cycle PC-redirect pulse.
- jump_target  out  PC_W  redirect address; valid while jump=1, else 0.
- depth  out  $clog2(DEPTH+1)  current stack occupancy.
- overflow  out  1  sticky: push attempted while full.
- underflow  out  1  sticky: close with empty stack in RUN.
- peak_depth  out  $clog2(DEPTH+1)  see Optional Feature.

Behaviour:
- Reset (async assert, any state): state=RUN, stack empty, depth=0, skip_cnt=0.
  - skip, jump, jump_target, overflow, underflow and peak_depth all go to 0.
- Event = instr_valid & (is_open ^ is_close).
  - is_open & is_close both high: no-op, no flag set.
  - instr_valid=0: no change.
- All outputs are registered; state, stack and flags update on the rising edge.
- RUN, open, acc_zero=0: push pc; depth+1.
  - If full: no push, overflow<=1, state unchanged.
- RUN, open, acc_zero=1: state<=SKIP, skip_cnt<=1; no push.
- RUN, close, acc_zero=0, stack non-empty: jump<=1 next cycle, jump_target<=top+1 (mod 2^PC_W).
  - Stack unchanged; the loop re-enters.
- RUN, close, acc_zero=1, stack non-empty: pop; depth-1; no jump.
- RUN, close, stack empty: underflow<=1; no jump, no pop, regardless of acc_zero.
- SKIP:
  - skip=1 from the cycle after entry.
  - acc_zero is ignored; the stack is frozen.
  - open: skip_cnt+1. At all-ones, saturate and set overflow.
  - close: skip_cnt-1. On reaching 0, state<=RUN, skip=0 next cycle. The matching close is consumed: no pop, no jump.
  - skip_cnt never underflows.
- jump pulse:
  - Exactly one cycle long; it follows the close edge.
  - Consecutive closes on back-to-back cycles give back-to-back pulses, each using the current top.
  - Upstream stops presenting instructions while jump is high.
- Flags:
  - overflow and underflow stay set until reset.
  - A flag-setting event causes no other state change.
- Push/pop never happen in the same cycle: only one event per cycle.
- depth equals the number of valid entries at all times.

Optional Feature:
- Macro LOOP_UNIT_PEAK_DEPTH_EN.
- Defined:
  - peak_depth tracks the maximum depth reached since reset.
  - It updates in the same edge as the push that raises it.
  - It never decreases except on reset.
- Undefined:
  - peak_depth is tied to 0.
  - No peak register is synthesized.
  - All other behaviour is identical.

Test Plan:
- Reset mid-SKIP (skip_cnt=2): assert reset asynchronously between edges -> skip, depth, flags and jump drop to 0 immediately; next open with acc_zero=0 pushes normally.
- Simple loop: open pc=0x0010 acc_zero=0, then close pc=0x0014 acc_zero=0 -> depth=1; next cycle jump=1, jump_target=0x0011 for one cycle. Then close acc_zero=1 -> depth=0, no jump.
- Nested skip: open pc=0x0020 acc_zero=1, open, open, close, close, close -> skip=1 across the body; skip=0 the cycle after the 3rd close; depth stays 0; no jump.
- Overflow: DEPTH=16, 17 opens with acc_zero=0 at pc=0..16 -> depth=16, overflow=1 after the 17th. A following close acc_zero=0 jumps to 0x0010 (top=15, +1).
- Underflow: close with empty stack, acc_zero=0 -> underflow=1, jump stays 0, depth=0. Flag remains set after 10 more valid instructions.
- Peak (macro defined): push 3, pop 2, push 1 -> peak_depth=3, depth=2. With macro undefined, peak_depth=0 throughout.

Source files
------------

// File: rtl/loop_unit.sv
// loop_unit: loop-bracket control stage downstream of the accumulator unit.
// Pushes loop-start PCs, issues back-jumps on close, and runs forward skip
// scans over loop bodies whose entry condition (acc_zero) is already met.
// Optional feature macro: LOOP_UNIT_PEAK_DEPTH_EN (peak stack occupancy tracker).
module loop_unit #(
  parameter int unsigned PC_W   = 16,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned SKIP_W = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         instr_valid,
  input  logic                         is_open,
  input  logic                         is_close,
  input  logic [PC_W-1:0]              pc,
  input  logic                         acc_zero,
  output logic                         skip,
  output logic                         jump,
  output logic [PC_W-1:0]              jump_target,
  output logic [$clog2(DEPTH+1)-1:0]   depth,
  output logic                         overflow,
  output logic                         underflow,
  output logic [$clog2(DEPTH+1)-1:0]   peak_depth
);

  localparam int unsigned DW = $clog2(DEPTH + 1);
  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_SKIP = 1'b1
  } state_t;

  state_t              state_q;
  logic [SKIP_W-1:0]   skip_cnt_q;
  logic [PC_W-1:0]     stack_q [DEPTH];
  logic [DW-1:0]       depth_q;
  logic                skip_q;
  logic                jump_q;
  logic [PC_W-1:0]     target_q;
  logic                ovf_q;
  logic                unf_q;

  logic                open_ev_c;
  logic                close_ev_c;
  logic                full_c;
  logic                empty_c;
  logic                push_c;
  logic [PC_W-1:0]     top_c;
  logic [DW-1:0]       depth_inc_d;
  logic [DW-1:0]       depth_dec_d;

  // Event decode and stack-pointer arithmetic
  always_comb begin
    open_ev_c   = instr_valid & is_open & ~is_close;
    close_ev_c  = instr_valid & is_close & ~is_open;
    full_c      = (depth_q == DW'(DEPTH));
    empty_c     = (depth_q == '0);
    push_c      = (state_q == ST_RUN) & open_ev_c & ~acc_zero & ~full_c;
    depth_inc_d = depth_q + DW'(1);
    depth_dec_d = depth_q - DW'(1);
    top_c       = stack_q[AW'(depth_dec_d)];
  end

  // Loop FSM: stack, skip-scan nesting counter, jump pulse and sticky flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_RUN;
      skip_cnt_q <= '0;
      depth_q    <= '0;
      skip_q     <= 1'b0;
      jump_q     <= 1'b0;
      target_q   <= '0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        stack_q[i] <= '0;
      end
    end else begin
      jump_q   <= 1'b0;
      target_q <= '0;
      case (state_q)
        ST_RUN: begin
          if (open_ev_c) begin
            if (acc_zero) begin
              state_q    <= ST_SKIP;
              skip_cnt_q <= SKIP_W'(1);
              skip_q     <= 1'b1;
            end else if (full_c) begin
              ovf_q <= 1'b1;
            end else begin
              stack_q[AW'(depth_q)] <= pc;
              depth_q               <= depth_inc_d;
            end
          end else if (close_ev_c) begin
            if (empty_c) begin
              unf_q <= 1'b1;
            end else if (acc_zero) begin
              depth_q <= depth_dec_d;
            end else begin
              jump_q   <= 1'b1;
              target_q <= top_c + PC_W'(1);
            end
          end
        end
        ST_SKIP: begin
          if (open_ev_c) begin
            if (skip_cnt_q == '1) begin
              ovf_q <= 1'b1;
            end else begin
              skip_cnt_q <= skip_cnt_q + SKIP_W'(1);
            end
          end else if (close_ev_c && skip_cnt_q != '0) begin
            skip_cnt_q <= skip_cnt_q - SKIP_W'(1);
            if (skip_cnt_q == SKIP_W'(1)) begin
              state_q <= ST_RUN;
              skip_q  <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= ST_RUN;
        end
      endcase
    end
  end

`ifdef LOOP_UNIT_PEAK_DEPTH_EN
  logic [DW-1:0] peak_q;

  // High-water mark of stack occupancy, raised on the same edge as the push
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      peak_q <= '0;
    end else if (push_c && (depth_inc_d > peak_q)) begin
      peak_q <= depth_inc_d;
    end
  end

  assign peak_depth = peak_q;
`else
  logic unused_push_c;
  assign unused_push_c = push_c;
  assign peak_depth    = '0;
`endif

  assign skip        = skip_q;
  assign jump        = jump_q;
  assign jump_target = target_q;
  assign depth       = depth_q;
  assign overflow    = ovf_q;
  assign underflow   = unf_q;

endmodule

// File: tb/tb_loop_unit.sv
// tb_loop_unit: table-driven scoreboard bench for loop_unit plus hand-written
// sequences for reset mid-skip, stack overflow, underflow persistence and peak depth.
module tb_loop_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic        is_open;
  logic        is_close;
  logic [15:0] pc;
  logic        acc_zero;
  logic        skip;
  logic        jump;
  logic [15:0] jump_target;
  logic [4:0]  depth;
  logic        overflow;
  logic        underflow;
  logic [4:0]  peak_depth;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  loop_unit #(.PC_W(16), .DEPTH(16), .SKIP_W(8)) dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .is_open(is_open),
    .is_close(is_close), .pc(pc), .acc_zero(acc_zero), .skip(skip), .jump(jump),
    .jump_target(jump_target), .depth(depth), .overflow(overflow),
    .underflow(underflow), .peak_depth(peak_depth)
  );

  typedef struct {
    logic        v, o, c;
    logic [15:0] pc;
    logic        az;
    logic        e_skip, e_jump;
    logic [15:0] e_tgt;
    logic [4:0]  e_depth;
    logic        e_ovf, e_unf;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];

  function automatic vec_t mk(logic v, logic o, logic c, logic [15:0] p, logic az,
                              logic es, logic ej, logic [15:0] et, logic [4:0] ed,
                              logic eo, logic eu);
    vec_t r;
    r.v = v; r.o = o; r.c = c; r.pc = p; r.az = az;
    r.e_skip = es; r.e_jump = ej; r.e_tgt = et; r.e_depth = ed;
    r.e_ovf = eo; r.e_unf = eu;
    return r;
  endfunction

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Drive one instruction, advance one edge, sample 1ns later
  task automatic step(input logic v, input logic o, input logic c,
                      input logic [15:0] p, input logic az);
    instr_valid = v; is_open = o; is_close = c; pc = p; acc_zero = az;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    instr_valid = 1'b0; is_open = 1'b0; is_close = 1'b0; pc = '0; acc_zero = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_skip"},  32'(skip), 0);
    check({tag, "_jump"},  32'(jump), 0);
    check({tag, "_tgt"},   32'(jump_target), 0);
    check({tag, "_depth"}, 32'(depth), 0);
    check({tag, "_ovf"},   32'(overflow), 0);
    check({tag, "_unf"},   32'(underflow), 0);
    check({tag, "_peak"},  32'(peak_depth), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t e;
    int unsigned exp_peak;

    // Simple loop, nested skip, no-op encodings, underflow
    vecs.push_back(mk(1,1,0,16'h0010,0, 0,0,16'h0000,1, 0,0));
    vecs.push_back(mk(1,0,1,16'h0014,0, 0,1,16'h0011,1, 0,0));
    vecs.push_back(mk(0,0,0,16'h0000,0, 0,0,16'h0000,1, 0,0));
    vecs.push_back(mk(1,0,1,16'h0014,1, 0,0,16'h0000,0, 0,0));
    vecs.push_back(mk(1,1,0,16'h0020,1, 1,0,16'h0000,0, 0,0));
    vecs.push_back(mk(1,1,0,16'h0021,0, 1,0,16'h0000,0, 0,0));
    vecs.push_back(mk(1,1,0,16'h0022,0, 1,0,16'h0000,0, 0,0));
    vecs.push_back(mk(1,0,1,16'h0023,0, 1,0,16'h0000,0, 0,0));
    vecs.push_back(mk(1,0,1,16'h0024,0, 1,0,16'h0000,0, 0,0));
    vecs.push_back(mk(1,0,1,16'h0025,0, 0,0,16'h0000,0, 0,0));
    vecs.push_back(mk(1,1,1,16'h0026,0, 0,0,16'h0000,0, 0,0));
    vecs.push_back(mk(0,1,0,16'h0027,0, 0,0,16'h0000,0, 0,0));
    vecs.push_back(mk(1,0,1,16'h0028,0, 0,0,16'h0000,0, 0,1));
    vecs.push_back(mk(1,0,1,16'h0029,1, 0,0,16'h0000,0, 0,1));

    reset = 1'b1;
    instr_valid = 1'b0; is_open = 1'b0; is_close = 1'b0; pc = '0; acc_zero = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b0;

    foreach (vecs[i]) begin
      exp_q.push_back(vecs[i]);
      step(vecs[i].v, vecs[i].o, vecs[i].c, vecs[i].pc, vecs[i].az);
      e = exp_q.pop_front();
      check($sformatf("v%0d_skip", i),  32'(skip),        32'(e.e_skip));
      check($sformatf("v%0d_jump", i),  32'(jump),        32'(e.e_jump));
      check($sformatf("v%0d_tgt", i),   32'(jump_target), 32'(e.e_tgt));
      check($sformatf("v%0d_depth", i), 32'(depth),       32'(e.e_depth));
      check($sformatf("v%0d_ovf", i),   32'(overflow),    32'(e.e_ovf));
      check($sformatf("v%0d_unf", i),   32'(underflow),   32'(e.e_unf));
    end

    // Underflow flag survives ten further valid instructions
    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 0) step(1, 1, 0, 16'(i), 0);
      else            step(1, 0, 1, 16'(i), 1);
    end
    check("unf_sticky", 32'(underflow), 1);
    check("unf_sticky_depth", 32'(depth), 0);

    // Reset asserted between edges while skip_cnt=2
    step(1, 1, 0, 16'h0030, 0);
    step(1, 1, 0, 16'h0031, 1);
    step(1, 1, 0, 16'h0032, 0);
    check("preskip_skip", 32'(skip), 1);
    check("preskip_depth", 32'(depth), 1);
    #3;
    reset = 1'b1;
    #1;
    check_all_zero("midreset");
    @(posedge clk);
    #1;
    reset = 1'b0;
    step(1, 1, 0, 16'h0040, 0);
    check("postreset_depth", 32'(depth), 1);
    check("postreset_skip", 32'(skip), 0);
    step(1, 0, 1, 16'h0041, 0);
    check("postreset_jump", 32'(jump), 1);
    check("postreset_tgt", 32'(jump_target), 32'h0041);

    // Overflow: 17 opens into a 16-entry stack
    do_reset();
    for (int i = 0; i < 17; i++) begin
      step(1, 1, 0, 16'(i), 0);
      if (i == 15) check("ovf_before", 32'(overflow), 0);
    end
    check("ovf_depth", 32'(depth), 16);
    check("ovf_flag", 32'(overflow), 1);
    step(1, 0, 1, 16'h0100, 0);
    check("ovf_jump", 32'(jump), 1);
    check("ovf_tgt", 32'(jump_target), 32'h0010);
    step(1, 0, 1, 16'h0100, 0);
    check("b2b_jump", 32'(jump), 1);
    check("b2b_tgt", 32'(jump_target), 32'h0010);
    step(0, 0, 0, 16'h0000, 0);
    check("b2b_end_jump", 32'(jump), 0);
    check("b2b_end_depth", 32'(depth), 16);

    // Peak depth: push 3, pop 2, push 1
    do_reset();
    check("peak_reset", 32'(peak_depth), 0);
    step(1, 1, 0, 16'h0001, 0);
    step(1, 1, 0, 16'h0002, 0);
    step(1, 1, 0, 16'h0003, 0);
    step(1, 0, 1, 16'h0004, 1);
    step(1, 0, 1, 16'h0005, 1);
    step(1, 1, 0, 16'h0006, 0);
    step(0, 0, 0, 16'h0000, 0);
`ifdef LOOP_UNIT_PEAK_DEPTH_EN
    exp_peak = 3;
`else
    exp_peak = 0;
`endif
    check("peak_depth", 32'(peak_depth), exp_peak);
    check("peak_cur_depth", 32'(depth), 2);
    step(1, 0, 1, 16'h0007, 0);
    check("peak_top_tgt", 32'(jump_target), 32'h0007);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
